// File: rtl/output_deskew_pkg.sv
// -----------------------------------------------------------------------------
// output_deskew_pkg
// Shared systolic-array definitions for the output deskew block:
//   - default geometry (lanes, accumulator width, row FIFO depth, tile rows)
//   - deskew FSM state encoding
//   - idx_width(): counter/pointer width helper that never returns 0
// -----------------------------------------------------------------------------
package output_deskew_pkg;

  localparam int DEF_LANES         = 16;
  localparam int DEF_DW            = 20;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_ROWS_PER_TILE = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Width of a counter/pointer indexing n entries; at least one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/output_deskew_delay_line.sv
// -----------------------------------------------------------------------------
// deskew_delay_line
// Per-lane shift-enabled delay of DEPTH registers. DEPTH=0 degenerates to a
// plain wire from d to q.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset, clears every stage
//   shift  in  advance the line by one stage; hold otherwise
//   d      in  [DW-1:0] lane input
//   q      out [DW-1:0] lane input delayed by DEPTH shifts
// -----------------------------------------------------------------------------
module deskew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    // Control inputs are intentionally unused on the zero-delay lane.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, reset, shift};
    assign q = d;
  end else begin : g_regs
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [DW-1:0] stage_q;
      logic [DW-1:0] stage_d;

      if (gi == 0) begin : g_first
        assign stage_d = d;
      end else begin : g_next
        assign stage_d = g_stage[gi-1].stage_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage_q <= '0;
        end else if (shift) begin
          stage_q <= stage_d;
        end
      end
    end

    assign q = g_stage[DEPTH-1].stage_q;
  end

endmodule

// File: rtl/output_deskew.sv
// -----------------------------------------------------------------------------
// output_deskew
// Realigns the skewed output columns of a systolic array (lane k lags lane 0
// by k cycles) into whole rows, buffers them in a small row FIFO with
// valid/ready handshake and marks the last row of every tile.
// Ports:
//   clk        in  rising-edge clock
//   reset      in  asynchronous active-high reset
//   en         in  shift enable for the skewed input
//   in_valid   in  lane-0 element of a new row present on din
//   din        in  [LANES*DW-1:0] skewed lanes, lane 0 in MSBs
//   flush      in  single-cycle drain request (honoured only in RUN)
//   dout       out [LANES*DW-1:0] aligned row, lane 0 in MSBs (0 when empty)
//   out_valid  out row available
//   out_ready  in  consumer accepts the row
//   out_last   out current row is the last row of a tile
//   busy       out deskew FSM not idle
//   overflow   out sticky flag: a row was dropped on a full FIFO
// Build option: define OUTPUT_DESKEW_OVF_FLAG_EN to implement the sticky
// overflow register; otherwise overflow is tied low (rows are still dropped).
// -----------------------------------------------------------------------------
module output_deskew
  import output_deskew_pkg::*;
#(
  parameter int LANES         = DEF_LANES,
  parameter int DW            = DEF_DW,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int ROWS_PER_TILE = DEF_ROWS_PER_TILE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                in_valid,
  input  logic [LANES*DW-1:0] din,
  input  logic                flush,
  output logic [LANES*DW-1:0] dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                overflow
);

  localparam int TW = LANES - 1;
  localparam int RW = LANES * DW;
  localparam int PW = idx_width(FIFO_DEPTH);
  localparam int CW = idx_width(ROWS_PER_TILE);
  localparam int FW = idx_width(LANES);

  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_ROW   = CW'(ROWS_PER_TILE - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(LANES - 2);

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          flushing, shift;
  logic [RW-1:0] din_eff, row_aligned;

  assign flushing = (state_q == ST_FLUSH);
  assign shift    = en | flushing;
  // While draining, the pipeline is fed with zeros and no new rows.
  assign din_eff  = flushing ? '0 : din;

  // ---------------------------------------------------------------- lanes
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    deskew_delay_line #(
      .DEPTH(LANES - 1 - gi),
      .DW   (DW)
    ) u_delay (
      .clk  (clk),
      .reset(reset),
      .shift(shift),
      .d    (din_eff[(LANES-gi)*DW-1 -: DW]),
      .q    (row_aligned[(LANES-gi)*DW-1 -: DW])
    );
  end

  // ------------------------------------------------------------- tag line
  // Bit 0 holds the newest tag; bit TW-1 lines up with the aligned row.
  logic [TW-1:0] tag_q, tag_d;
  logic [TW:0]   tag_shifted;
  logic          tag_out;

  assign tag_shifted = {tag_q, in_valid & ~flushing};
  assign tag_d       = shift ? tag_shifted[TW-1:0] : tag_q;
  assign tag_out     = tag_q[TW-1];

  // -------------------------------------------------------------- row FIFO
  logic [RW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic          push_req, push, pop, full, drop;

  assign full      = (count_q == FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push_req  = shift & tag_out;
  // A pop in the same cycle frees the slot being written, even when full.
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  assign dout     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last = out_valid & (row_cnt_q == LAST_ROW);
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    row_cnt_d = row_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + CW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= row_aligned;
  end

  // ------------------------------------------------------------------ FSM
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_FLUSH;
          fcnt_d  = '0;
        end else if (tag_q == '0 && !in_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // LANES-1 drain cycles empty the whole tag line.
        if (fcnt_q == FLUSH_LAST) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fcnt_q    <= '0;
      tag_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      tag_q     <= tag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // -------------------------------------------------------------- overflow
`ifdef OUTPUT_DESKEW_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  assign ovf_d = ovf_q | drop;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign overflow = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_output_deskew.sv
module tb_output_deskew;

  localparam int LANES = 16;
  localparam int DW    = 20;
  localparam int DEPTH = 4;
  localparam int ROWS  = 16;
  localparam int W     = LANES * DW;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic         clk = 1'b0;
  logic         reset, en, in_valid, flush, out_ready;
  logic         out_valid, out_last, busy, overflow;
  logic [W-1:0] din, dout;

  always #5 clk = ~clk;

  output_deskew #(
    .LANES(LANES), .DW(DW), .FIFO_DEPTH(DEPTH), .ROWS_PER_TILE(ROWS)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .din(din),
    .flush(flush), .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, obs, exp);
  endtask

  // ---------------- reference model: rows in flight + output queue
  int           m_mode, m_flush_left, m_rows, n_pops;
  bit           m_ovf, m_shift;
  logic [W-1:0] m_fifo[$];
  logic [W-1:0] p_data[$];
  int           p_age[$];
  // stimulus source: rows currently being presented skewed on din
  logic [W-1:0] s_data[$];
  int           s_age[$];

  function automatic bit exp_ovf();
`ifdef OUTPUT_DESKEW_OVF_FLAG_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_flush_left = 0; m_rows = 0; m_ovf = 0; m_shift = 0;
    m_fifo.delete(); p_data.delete(); p_age.delete();
    s_data.delete(); s_age.delete();
  endtask

  // Applies one clock edge using the inputs presented before it.
  task automatic model_edge();
    bit flushing, pop, vin;
    int next_mode;
    logic [W-1:0] e, tmp;
    m_shift = 0;
    if (reset) return;
    flushing  = (m_mode == M_FLUSH);
    m_shift   = en || flushing;
    pop       = (m_fifo.size() > 0) && out_ready;
    next_mode = m_mode;
    if (m_mode == M_IDLE) begin
      if (in_valid && en) next_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (flush) begin next_mode = M_FLUSH; m_flush_left = LANES - 1; end
      else if (p_data.size() == 0 && !in_valid) next_mode = M_IDLE;
    end else begin
      m_flush_left--;
      if (m_flush_left == 0) next_mode = M_IDLE;
    end
    if (pop) begin
      tmp = m_fifo.pop_front();
      $display("row %0d out lane0=%h last=%0b", n_pops, tmp[W-1 -: DW], m_rows == ROWS - 1);
      m_rows = (m_rows + 1) % ROWS;
      n_pops++;
    end
    if (m_shift) begin
      e   = flushing ? '0 : din;
      vin = in_valid && !flushing;
      if (vin) begin p_data.push_back('0); p_age.push_back(0); end
      // each in-flight row collects the lane whose index equals its age
      for (int i = 0; i < p_data.size(); i++) begin
        tmp = p_data[i];
        tmp[(LANES-p_age[i])*DW-1 -: DW] = e[(LANES-p_age[i])*DW-1 -: DW];
        p_data[i] = tmp;
        p_age[i]  = p_age[i] + 1;
      end
      if (p_age.size() > 0 && p_age[0] == LANES) begin
        tmp = p_data.pop_front();
        void'(p_age.pop_front());
        if (m_fifo.size() < DEPTH) m_fifo.push_back(tmp);
        else m_ovf = 1;
      end
    end
    m_mode = next_mode;
  endtask

  task automatic compare_outputs();
    bit v;
    v = (m_fifo.size() > 0);
    check("out_valid", W'(out_valid), W'(v));
    check("dout", dout, v ? m_fifo[0] : '0);
    check("out_last", W'(out_last), W'(v && m_rows == ROWS - 1));
    check("busy", W'(busy), W'(m_mode != M_IDLE));
    check("overflow", W'(overflow), W'(exp_ovf()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  // One cycle of stimulus: optionally start a new row, present all source
  // rows skewed (lane = age), random filler on the other lanes.
  task automatic cycle(input bit new_row, input logic [W-1:0] rdata,
                       input bit en_v, input bit fl_v, input bit rdy_v);
    logic [W-1:0] d, tmp;
    for (int k = 0; k < LANES; k++) d[(LANES-k)*DW-1 -: DW] = DW'($urandom);
    if (new_row) begin s_data.push_back(rdata); s_age.push_back(0); end
    for (int i = 0; i < s_data.size(); i++) begin
      tmp = s_data[i];
      d[(LANES-s_age[i])*DW-1 -: DW] = tmp[(LANES-s_age[i])*DW-1 -: DW];
    end
    din = d; in_valid = new_row; en = en_v; flush = fl_v; out_ready = rdy_v;
    tick();
    if (m_shift) begin
      for (int i = 0; i < s_age.size(); i++) s_age[i] = s_age[i] + 1;
      while (s_age.size() > 0 && s_age[0] >= LANES) begin
        void'(s_age.pop_front()); void'(s_data.pop_front());
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((m_mode != M_IDLE || m_fifo.size() > 0) && n < 300) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    check(tag, W'(busy | out_valid), W'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, W'(out_valid), W'(0));
    check({tag, "_dout"}, dout, '0);
    check({tag, "_last"}, W'(out_last), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_ovf"}, W'(overflow), W'(0));
  endtask

  function automatic logic [W-1:0] neg_row(input int j);
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[(LANES-k)*DW-1 -: DW] = DW'(-(k + 1) * (j + 1));
    return r;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[(LANES-k)*DW-1 -: DW] = DW'($urandom);
    return r;
  endfunction

  initial begin
    int lat, cnt;
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; din = '0; flush = 1'b0; out_ready = 1'b0;
    n_pops = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // single row, lane k = -(k+1)
    cycle(1'b1, neg_row(0), 1'b1, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 40) begin cycle(1'b0, '0, 1'b1, 1'b0, 1'b1); lat++; end
    check("single_latency", W'(lat), W'(LANES));
    check("single_row", dout, neg_row(0));
    drain("single_idle");

    // 30 back-to-back rows
    for (int j = 0; j < 30; j++) cycle(1'b1, neg_row(j), 1'b1, 1'b0, 1'b1);
    drain("b2b_idle");
    check("b2b_ovf", W'(overflow), W'(0));

    // stalled consumer: 6 rows into a 4-deep FIFO
    for (int j = 0; j < 6; j++) cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("stall_valid", W'(out_valid), W'(1));
`ifdef OUTPUT_DESKEW_OVF_FLAG_EN
    check("stall_ovf", W'(overflow), W'(1));
`else
    check("stall_ovf", W'(overflow), W'(0));
`endif
    cnt = 0;
    repeat (8) begin
      if (out_valid) cnt++;
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    check("stall_rows", W'(cnt), W'(DEPTH));

    // en low for 5 cycles mid-stream
    for (int j = 0; j < 10; j++) begin
      if (j == 5) repeat (5) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    end
    drain("engap_idle");

    // flush 3 cycles after the last in_valid
    for (int j = 0; j < 3; j++) cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    cnt = 0;
    while (busy && cnt < 40) begin cnt++; cycle(1'b0, '0, 1'b1, 1'b0, 1'b1); end
    check("flush_cycles", W'(cnt), W'(LANES - 1));
    drain("flush_idle");

    // reset at cycle 8 of a 30-row stream
    for (int j = 0; j < 8; j++) cycle(1'b1, neg_row(j), 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    check_all_zero("midrst");
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      if (out_valid) cnt++;
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    check("midrst_rows", W'(cnt), W'(0));

    // randomized traffic
    repeat (1200) begin
      cycle($urandom_range(0, 2) != 0, rand_row(), $urandom_range(0, 7) != 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
    end
    drain("random_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/output_deskew.md
OUTPUT_DESKEW -- requirements
Module: output_deskew

Interface
REQ-001 SHALL have parameter LANES, default 16, number of systolic-array output columns.
REQ-002 SHALL have parameter DW, default 20, accumulator width per lane.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, aligned-row buffer entries (power of two, >=2).
REQ-004 SHALL have parameter ROWS_PER_TILE, default 16, rows per tile for out_last generation.
REQ-005 SHALL have ports: clk in 1 (single clock, rising edge); reset in 1 (asynchronous, active-high); en in 1 (shift enable for skewed input); in_valid in 1 (lane-0 element of a new row present); din in LANES*DW (lane 0 in MSBs, skewed: lane k lags lane 0 by k cycles); flush in 1 (single-cycle drain request); dout out LANES*DW (aligned row, lane 0 in MSBs); out_valid out 1; out_ready in 1; out_last out 1 (last row of tile); busy out 1 (FSM not IDLE); overflow out 1 (sticky drop flag).

Function
REQ-006 Lane k SHALL pass through a delay line of LANES-1-k registers; lane LANES-1 SHALL have zero delay.
REQ-007 in_valid SHALL travel through a LANES-1 stage tag line, in step with lane 0 data.
REQ-008 Delay and tag lines SHALL shift only when en=1 or FSM is in FLUSH; otherwise they SHALL hold.
REQ-009 When the tag line output is 1 on a shifting cycle, the aligned row SHALL be written into the row FIFO at that clock edge.
REQ-010 Latency: with en=1 continuously and FIFO empty, a row whose lane 0 enters at cycle t SHALL appear with out_valid=1 at cycle t+LANES.
REQ-011 FIFO pop SHALL occur when out_valid=1 and out_ready=1; dout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-012 Simultaneous push and pop SHALL both occur, with occupancy unchanged, including when the FIFO is full.
REQ-013 Push to a full FIFO without simultaneous pop SHALL drop the row, leave FIFO contents unchanged and set overflow.
REQ-014 A row counter (width clog2(ROWS_PER_TILE)) SHALL increment on each pop, wrap to 0 after ROWS_PER_TILE-1, and out_last SHALL equal out_valid AND (counter == ROWS_PER_TILE-1).
REQ-015 FSM states: IDLE, RUN, FLUSH. IDLE->RUN on in_valid&en. RUN->FLUSH on flush. RUN->IDLE when the tag line is all-zero and in_valid=0. FLUSH runs exactly LANES-1 cycles, then goes to IDLE.
REQ-016 flush in IDLE SHALL be ignored. flush while in FLUSH SHALL be ignored.
REQ-017 In FLUSH, in_valid SHALL be treated as 0, and din SHALL be shifted in as zero.
REQ-018 Pending rows reaching the tag output in FLUSH SHALL be pushed per REQ-009/013.
REQ-019 busy SHALL be 1 in RUN and FLUSH, and 0 in IDLE.

Reset
REQ-020 On reset, all delay registers, tag line, FIFO pointers, occupancy and row counter SHALL clear to 0, and the FSM SHALL go to IDLE.
REQ-021 On reset, out_valid, out_last, busy and overflow SHALL be 0, and dout SHALL be 0.
REQ-022 Reset mid-stream SHALL discard all in-flight and buffered rows, with no partial row emitted afterward.

Configuration
REQ-023 Macro OUTPUT_DESKEW_OVF_FLAG_EN defined: overflow SHALL be a sticky register cleared only by reset.
REQ-024 Macro OUTPUT_DESKEW_OVF_FLAG_EN undefined: overflow SHALL be tied to 0, and drops SHALL still occur per REQ-013.

Structure
REQ-025 LANES, DW, FIFO_DEPTH, ROWS_PER_TILE defaults and the FSM state encoding SHALL reside in the shared systolic-array package.
REQ-026 The per-lane delay SHALL be a sub-module deskew_delay_line (parameters DEPTH, DW; ports clk, reset, shift, d, q).
REQ-027 deskew_delay_line SHALL be a wire pass-through when DEPTH=0.

Verification
REQ-028 Single row, lane k value = -(k+1) applied at cycle t+k, out_ready=1 -> one row at t+16, lane k = -(k+1) (20-bit two's complement), busy returns to 0.
REQ-029 30 back-to-back skewed rows, row j lane k = -(k+1)(j+1), out_ready=1 -> 30 rows in order.
REQ-030 Continuation of REQ-029 -> out_last on rows 16 and 32-wrap (row index 15), overflow=0.
REQ-031 out_ready=0, 6 rows injected -> 4 buffered, rows 5-6 dropped, overflow=1 (macro defined) or 0 (undefined).
REQ-032 Continuation of REQ-031: then out_ready=1 -> rows 1-4 delivered intact.
REQ-033 en=0 for 5 cycles mid-stream -> outputs frozen, no duplication or loss; en=1 -> stream resumes with latency extended by 5.
REQ-034 flush 3 cycles after last in_valid -> FSM in FLUSH for 15 cycles, last row emitted, then IDLE.
REQ-035 reset at cycle 8 of a 30-row stream -> all outputs 0 next cycle, no rows emitted until new in_valid.
